// File: rtl/serial_mod5_frame_tx.sv
// serial_mod5_frame_tx: MSB-first serial framer that appends 3 check bits making the frame divisible by 5.
// Check bits and remainder tracking exist only when SERIAL_MOD5_CHECK_EN is defined.
module serial_mod5_frame_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last
);
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_bit_q, out_bit_d;
  logic              out_last_q, out_last_d;
  logic              xfer;
`ifdef SERIAL_MOD5_CHECK_EN
  logic [2:0]        r_q, r_d, chk_q, chk_d, r_nx;
  logic [3:0]        t;
`endif
  assign in_ready  = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign xfer      = out_valid_q && out_ready;
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_MOD5_CHECK_EN
    r_d   = r_q;
    chk_d = chk_q;
    t     = {r_q, 1'b0} + {3'b0, sh_q[DATA_W-1]};
    r_nx  = t >= 4'd5 ? 3'(t - 4'd5) : t[2:0];
`endif
    if (state_q == IDLE && in_valid) begin
      state_d = DATA;
      sh_d    = in_data;
      cnt_d   = 6'(DATA_W - 1);
`ifdef SERIAL_MOD5_CHECK_EN
      r_d     = 3'd0;
`endif
    end else if (xfer && state_q == DATA) begin
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - 6'd1;
`ifdef SERIAL_MOD5_CHECK_EN
      r_d   = r_nx;
      if (cnt_q == 6'd0) begin
        state_d = CHECK;
        cnt_d   = 6'd2;
        // c = (-8r) mod 5 so that data*8 + c is a multiple of 5
        chk_d   = r_nx == 3'd1 ? 3'd2 : r_nx == 3'd2 ? 3'd4 : r_nx == 3'd3 ? 3'd1 : r_nx == 3'd4 ? 3'd3 : 3'd0;
      end
    end else if (xfer && state_q == CHECK) begin
      chk_d = chk_q << 1;
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd0) begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
`else
      if (cnt_q == 6'd0) begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
`endif
    end
    out_valid_d = state_d != IDLE;
`ifdef SERIAL_MOD5_CHECK_EN
    out_bit_d  = state_d == DATA ? sh_d[DATA_W-1] : state_d == CHECK ? chk_d[2] : 1'b0;
    out_last_d = state_d == CHECK && cnt_d == 6'd0;
`else
    out_bit_d  = state_d == DATA ? sh_d[DATA_W-1] : 1'b0;
    out_last_d = state_d == DATA && cnt_d == 6'd0;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef SERIAL_MOD5_CHECK_EN
      r_q         <= '0;
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
`ifdef SERIAL_MOD5_CHECK_EN
      r_q         <= r_d;
      chk_q       <= chk_d;
`endif
    end
  end
endmodule

// File: doc/serial_mod5_frame_tx.md
# serial_mod5_frame_tx

Serial frame transmitter, the sending end of the mod-5 serial divisibility check. Accepts a `DATA_W`-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per accepted transfer. It then appends 3 check bits chosen so the whole frame, read as an unsigned binary number, is divisible by 5. A downstream mod-5 divisibility FSM, reset at frame start, asserts its divisible flag after the last bit of every correct frame.

## Interface
- `DATA_W`, 8: payload width in bits; legal range 1..32.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `in_valid` in 1: payload word offered.
- `in_ready` out 1: block can accept a word. Combinational, equals state==IDLE.
- `in_data` in `DATA_W`: payload word, sampled on accept.
- `out_valid` out 1: `out_bit` carries a frame bit.
- `out_ready` in 1: sink takes `out_bit` this cycle.
- `out_bit` out 1: current serial bit.
- `out_last` out 1: `out_bit` is the final bit of the frame.

## Operation
- FSM states: IDLE, DATA, CHECK.
  - IDLE: `out_valid`=0. On `in_valid`&&`in_ready`, load the shift register with `in_data`, set bit count=`DATA_W`-1, clear remainder r=0, go to DATA.
  - DATA: `out_valid`=1, `out_bit`=shift register MSB. On each transfer (`out_valid`&&`out_ready`):
    - r ← (2r+`out_bit`) mod 5 (3-bit register, values 0..4 only);
    - shift left;
    - decrement count.
  - Transfer with count=0: compute check c and load it into a 3-bit check register, go to CHECK.
  - CHECK: `out_bit`=check register MSB. Shift on each transfer. `out_last`=1 on the 3rd check bit. Transfer of the last bit goes to IDLE.
- Check value: c = (−8r) mod 5 = (−3r) mod 5. Mapping r→c: 0→0, 1→2, 2→4, 3→1, 4→3. Frame value = data·8 + c ≡ 0 mod 5.
- Backpressure: while `out_valid`&&!`out_ready`, `out_bit`, `out_last`, r, count and state are frozen.
- `in_data` is ignored outside the accept cycle; `in_valid` outside IDLE has no effect.
- Reset (any time, including mid-frame): state=IDLE, `out_valid`=0, `out_bit`=0, `out_last`=0, r=0, count=0, check register=0, `in_ready`=1 after reset. A partial frame is abandoned, not completed.

## Timing
- Accept at edge N → `out_valid`=1 with data MSB from cycle N+1.
- With `out_ready` held 1, a frame occupies `DATA_W`+3 consecutive cycles. `out_last` is high in the final cycle, then IDLE for ≥1 cycle.
- Minimum accept-to-accept interval: `DATA_W`+4 cycles.
- All outputs except `in_ready` are registered.

## Configuration
- `SERIAL_MOD5_CHECK_EN` defined: behaviour as above, frame length `DATA_W`+3.
- Not defined: CHECK state and check/remainder logic are compiled out. Frame is `DATA_W` bits; `out_last`=1 on the final data bit; DATA returns directly to IDLE.

## Test plan
- `DATA_W`=8, `in_data`=0x00, `out_ready`=1 → 11 bits 00000000_000; `out_last` only on bit 11; `in_ready` 0 for 11 cycles, then 1.
- `in_data`=0x01 → 00000001_010 (value 10). `in_data`=0x07 → 00000111_100 (value 60). A mod-5 checker flags divisible after bit 11 in both cases.
- `in_data`=0xFF (255, r=0) → 11111111_000. Random sweep over all 256 words: every frame value mod 5 = 0.
- Backpressure: `out_ready`=0 for 3 cycles at bit 5 of 0xA5 → `out_bit`/`out_valid` stable; resumed stream is identical to the unstalled stream.
- `rst`=0 asserted asynchronously mid-DATA → `out_valid`=0 immediately; next frame 0x01 is emitted correctly with no stale remainder.
- Macro undefined, `in_data`=0x81 → 8 bits 10000001; `out_last` on bit 8; no check bits.
